div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the execute stage. It accepts one RV32M divide/remainder op from decode and runs a radix-2 restoring divider over 32 iterations. It holds the pipeline while the divide is in progress, then presents the result for one cycle with rd address and write enable, muxed into the execute-stage writeback path. Divide-by-zero and signed overflow complete in a single cycle.

---
 rtl/div_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU.
// Holds the pipeline during the divide and presents the result for one cycle with rd and write enable.
module div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_addr_o,
  output logic                  rd_we_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Two's complement negate when the flag is set; used for operand magnitudes and sign correction.
  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (ALL_ZERO - v) : v;
  endfunction

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_is_rem;
  logic                  r_quot_neg;
  logic                  r_rem_neg;
  logic [4:0]            r_rd_addr;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quot;
  logic                  r_done;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_nx;
  logic [DATA_WIDTH-1:0] w_quot_nx;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_early_result;
  logic [DATA_WIDTH-1:0] w_calc_result;
  logic [DATA_WIDTH-1:0] w_result_sel;
  logic [1:0]            w_next;

  assign w_signed   = ~op_i[0];
  assign w_a_neg    = w_signed & dividend_i[DATA_WIDTH-1];
  assign w_b_neg    = w_signed & divisor_i[DATA_WIDTH-1];
  assign w_div_zero = (divisor_i == ALL_ZERO);
  assign w_ovf      = w_signed & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);
  assign w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;
  assign busy_o     = w_accept | (r_state == S_CALC);

  // The subtract runs one bit wider than the data so its top bit acts as the borrow (rem < divisor).
  assign w_rem_sh  = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_divisor};
  assign w_ge      = ~w_diff[DATA_WIDTH];
  assign w_rem_nx  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
  assign w_quot_nx = {r_quot[DATA_WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == LAST_CNT);

  // Result of a single-cycle op: zero divisor takes precedence over signed overflow.
  always_comb begin
    w_early_result = ALL_ZERO;
    if (w_div_zero) begin
      w_early_result = op_i[1] ? dividend_i : ALL_ONES;
    end else if (w_ovf) begin
      w_early_result = op_i[1] ? ALL_ZERO : MIN_NEG;
    end else begin
      w_early_result = ALL_ZERO;
    end
  end

  // Sign-corrected result of the final iteration, chosen by quotient/remainder op.
  always_comb begin
    w_calc_result = ALL_ZERO;
    if (r_is_rem) begin
      w_calc_result = cond_neg(w_rem_nx, r_rem_neg);
    end else begin
      w_calc_result = cond_neg(w_quot_nx, r_quot_neg);
    end
  end

  assign w_result_sel = (r_state == S_CALC) ? w_calc_result : w_early_result;

  // Next-state decode; flush always returns to IDLE and suppresses completion.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (w_div_zero | w_ovf) ? S_DONE : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_CALC;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_is_rem   <= 1'b0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_rd_addr  <= 5'd0;
      r_divisor  <= ALL_ZERO;
      r_rem      <= ALL_ZERO;
      r_quot     <= ALL_ZERO;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_result   <= ALL_ZERO;
    end else begin
      r_state  <= w_next;
      r_done   <= (w_next == S_DONE);
      r_we     <= (w_next == S_DONE);
      r_result <= (w_next == S_DONE) ? w_result_sel : ALL_ZERO;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_rem   <= op_i[1];
            r_quot_neg <= w_a_neg ^ w_b_neg;
            r_rem_neg  <= w_a_neg;
            r_rd_addr  <= rd_addr_i;
            r_divisor  <= cond_neg(divisor_i, w_b_neg);
            r_quot     <= cond_neg(dividend_i, w_a_neg);
            r_rem      <= ALL_ZERO;
            r_cnt      <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_CALC: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_cnt  <= r_cnt + CNT_ONE;
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  assign done_o    = r_done;
  assign rd_we_o   = r_we;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_addr;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, special cases, flush, reset and back-to-back.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  div_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current cycle and wait (bounded) for done; returns observations only.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output logic [4:0] rdo, output logic we, output int busy_bad,
                       output logic busy_done, output logic done_after, output int dcyc);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1;
    busy_bad = busy_o ? 0 : 1;
    step();
    start_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0000_0003; rd_addr_i = 5'd31;
    lat = 1;
    while (!done_o && lat < 60) begin
      if (!busy_o) busy_bad++;
      step();
      lat++;
    end
    res = result_o; rdo = rd_addr_o; we = rd_we_o; busy_done = busy_o; dcyc = cyc;
    step();
    done_after = done_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_o); end
    checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", rd_we_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h exp 0", rd_addr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    logic [31:0] res; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc;
    do_op(2'b01, 32'd100, 32'd7, 5'd9, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_res: got %h exp %h", res, 32'd14); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_lat: got %0d exp 33", lat); end
    checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL divu_rd: got %0d exp 9", rdo); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL divu_we: got %b exp 1", we); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL divu_busy: %0d cycles low, exp 0", bb); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL divu_busy_done: got %b exp 0", bd); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL divu_pulse: got %b exp 0", da); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL divu_res_idle: got %h exp 0", result_o); end
    do_op(2'b11, 32'd100, 32'd7, 5'd4, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_res: got %h exp 2", res); end
    checks++; if (rdo !== 5'd4) begin errors++; $display("FAIL remu_rd: got %0d exp 4", rdo); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd1, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max: got %h exp ffffffff", res); end
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd1, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL remu_max: got %h exp 1", res); end
  endtask

  task automatic test_signed();
    logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] exs [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd14, 32'hFFFF_FFFE};
    logic [31:0] res; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 2), res, lat, rdo, we, bb, bd, da, dc);
      checks++; if (res !== exs[i]) begin errors++; $display("FAIL signed_res[%0d]: got %h exp %h", i, res, exs[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL signed_lat[%0d]: got %0d exp 33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  ops [5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00};
    logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exs [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] res; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 20), res, lat, rdo, we, bb, bd, da, dc);
      checks++; if (res !== exs[i]) begin errors++; $display("FAIL special_res[%0d]: got %h exp %h", i, res, exs[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_lat[%0d]: got %0d exp 1", i, lat); end
      checks++; if (rdo !== 5'(i + 20)) begin errors++; $display("FAIL special_rd[%0d]: got %0d exp %0d", i, rdo, i + 20); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc;
    int seen = 0;
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd7;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done_o) seen++;
      step();
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL flush_done: got %b exp 0", done_o); end
    step();
    do_op(2'b01, 32'd9, 32'd3, 5'd8, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses exp 0", seen); end
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL flush_next_res: got %h exp 3", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL flush_next_lat: got %0d exp 33", lat); end
    start_i = 1'b1; flush_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b exp 0", busy_o); end
    step();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_idle: got %b exp 0", busy_o); end
    step();
  endtask

  task automatic test_ignore_start_and_reset();
    logic [31:0] res; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc;
    int seen = 0;
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd3;
    step();
    lat = 1;
    while (!done_o && lat < 60) begin
      start_i = (lat == 5);
      dividend_i = 32'd77; divisor_i = 32'd0; rd_addr_i = 5'd30; op_i = 2'b11;
      step();
      lat++;
    end
    start_i = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_lat: got %0d exp 33", lat); end
    checks++; if (result_o !== 32'd333) begin errors++; $display("FAIL ignore_res: got %h exp %h", result_o, 32'd333); end
    checks++; if (rd_addr_o !== 5'd3) begin errors++; $display("FAIL ignore_rd: got %0d exp 3", rd_addr_o); end
    step();
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd12;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b exp 0", done_o); end
    checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b exp 0", rd_we_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL rst_mid_res: got %h exp 0", result_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL rst_mid_rd: got %0d exp 0", rd_addr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy_o); end
    for (int c = 0; c < 40; c++) begin
      if (done_o) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses exp 0", seen); end
    do_op(2'b01, 32'd9, 32'd3, 5'd5, res, lat, rdo, we, bb, bd, da, dc);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL rst_recover_res: got %h exp 3", res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2; int lat; logic [4:0] rdo; logic we; int bb; logic bd; logic da; int dc1, dc2;
    do_op(2'b01, 32'd50, 32'd5, 5'd10, res1, lat, rdo, we, bb, bd, da, dc1);
    do_op(2'b01, 32'd9, 32'd2, 5'd11, res2, lat, rdo, we, bb, bd, da, dc2);
    checks++; if (res1 !== 32'd10) begin errors++; $display("FAIL b2b_res1: got %h exp %h", res1, 32'd10); end
    checks++; if (res2 !== 32'd4) begin errors++; $display("FAIL b2b_res2: got %h exp 4", res2); end
    checks++; if (dc2 - dc1 !== 34) begin errors++; $display("FAIL b2b_gap: got %0d exp 34", dc2 - dc1); end
    checks++; if (rdo !== 5'd11) begin errors++; $display("FAIL b2b_rd: got %0d exp 11", rdo); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_ignore_start_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
